// File: rtl/my_pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is split into STAGES registered
// chunks with a valid/ready handshake and full backpressure on both sides.
module my_pipe_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V
);

    localparam int unsigned CW = (STAGES == 0) ? WIDTH : WIDTH / STAGES;

    if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("my_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic adv;
    logic last_valid;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv      = ~last_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CW;

        // Operand bits not yet added (from chunk LO upward) and result bits already produced.
        logic [WIDTH-1:LO]   a_i;
        logic [WIDTH-1:LO]   b_i;
        logic                c_i;
        logic                vld_i;
        logic [LO+CW-1:0]    s_n;
        logic [CW:0]         sum;
        logic                vld_q;
        logic                c_q;
        logic [LO+CW-1:0]    s_q;

        if (k == 0) begin : g_in
            assign a_i   = A;
            assign b_i   = Sub ? ~B : B;
            assign c_i   = Sub | Ci;
            assign vld_i = in_valid;
            assign s_n   = sum[CW-1:0];
        end else begin : g_in
            assign a_i   = g_stage[k-1].g_skew.a_q;
            assign b_i   = g_stage[k-1].g_skew.b_q;
            assign c_i   = g_stage[k-1].c_q;
            assign vld_i = g_stage[k-1].vld_q;
            assign s_n   = {sum[CW-1:0], g_stage[k-1].s_q};
        end

        assign sum = {1'b0, a_i[LO +: CW]} + {1'b0, b_i[LO +: CW]} + {{CW{1'b0}}, c_i};

        // Data registers load only with a valid operation so idle X never reaches S.
        always_ff @(posedge clk) begin
            if (reset_p) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
            end else if (adv) begin
                vld_q <= vld_i;
                if (vld_i) begin
                    c_q <= sum[CW];
                    s_q <= s_n;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:LO+CW] a_q;
            logic [WIDTH-1:LO+CW] b_q;

            always_ff @(posedge clk) begin
                if (reset_p) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && vld_i) begin
                    a_q <= a_i[WIDTH-1:LO+CW];
                    b_q <= b_i[WIDTH-1:LO+CW];
                end
            end
        end else begin : g_last
            logic v_q;

            // Carry into the MSB is recovered as sum ^ a ^ b at bit WIDTH-1.
            always_ff @(posedge clk) begin
                if (reset_p) begin
                    v_q <= 1'b0;
                end else if (adv && vld_i) begin
                    v_q <= sum[CW] ^ sum[CW-1] ^ a_i[WIDTH-1] ^ b_i[WIDTH-1];
                end
            end
        end
    end

    assign last_valid = g_stage[STAGES-1].vld_q;
    assign out_valid  = last_valid;
    assign S          = g_stage[STAGES-1].s_q;
    assign Co         = g_stage[STAGES-1].c_q;
    assign V          = g_stage[STAGES-1].g_last.v_q;

endmodule
